ram_port_arbiter: RTL and testbench

Shares the CPU's single-port program RAM between two requesters: the external program loader, which writes, and the instruction fetch path, which reads. It sits between those requesters and the RAM module, and it sequences every access through a small FSM. The loader has priority, but a burst limit stops fetch from being starved. Each requester uses a req/ack handshake, and read data returns with a registered valid pulse.

---
 rtl/ram_port_arbiter.sv | 88 ++++++++
 tb/tb_ram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - loader/fetch arbiter for the single-port program RAM
module ram_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              fe_req,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic              fe_ack,
  output logic              fe_valid,
  output logic [DATA_W-1:0] fe_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       ld_win, fe_win;

  always_comb begin
    ld_win     = 1'b0;
    fe_win     = 1'b0;
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        // Loader wins unless fetch is waiting and the loader has used up its burst.
        if (ld_req && (!fe_req || streak < MAX_B)) begin
          ld_win     = 1'b1;
          state_nxt  = WRITE;
          streak_nxt = fe_req ? streak + 4'd1 : 4'd0;
        end else if (fe_req) begin
          fe_win     = 1'b1;
          state_nxt  = READ;
          streak_nxt = 4'd0;
        end
      end
      WRITE:     state_nxt = IDLE;
      READ:      state_nxt = READ_WAIT;
      READ_WAIT: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset kills them at once.
  assign ld_ack = (state == WRITE);
  assign ram_we = (state == WRITE);
  assign fe_ack = (state == READ);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= 4'd0;
      ram_addr <= '0;
      ram_din  <= '0;
      fe_data  <= '0;
      fe_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      streak   <= streak_nxt;
      fe_valid <= (state == READ_WAIT);
      if (state == READ_WAIT) begin
        fe_data <= ram_dout;
      end
      if (ld_win) begin
        ram_addr <= ld_addr;
        ram_din  <= ld_data;
      end else if (fe_win) begin
        ram_addr <= fe_addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int MAX_BURST = 4;

  logic       clk;
  logic       rst;
  logic       ld_req;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ack;
  logic       fe_req;
  logic [5:0] fe_addr;
  logic       fe_ack;
  logic       fe_valid;
  logic [7:0] fe_data;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack),
    .fe_valid(fe_valid), .fe_data(fe_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous read-first RAM standing in for the program memory.
  logic [7:0] ram [0:63] = '{0: 8'h11, 1: 8'h22, default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: each grant schedules its future output events.
  logic [7:0] m_mem [0:63] = '{0: 8'h11, 1: 8'h22, default: 8'h00};
  bit   [3:0] q_ld, q_fe, q_valid, q_busy;
  logic [7:0] q_data [0:3];
  int         m_streak;
  logic [5:0] m_ram_addr;
  logic [7:0] m_ram_din, m_fe_data;
  logic       ld_wins;

  initial begin
    q_ld = 0; q_fe = 0; q_valid = 0; q_busy = 0; m_streak = 0;
    m_ram_addr = 0; m_ram_din = 0; m_fe_data = 0;
    for (int i = 0; i < 4; i++) q_data[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_ld_ack", 32'(ld_ack), 0);
        check("rst_fe_ack", 32'(fe_ack), 0);
        check("rst_fe_valid", 32'(fe_valid), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din", 32'(ram_din), 0);
        check("rst_fe_data", 32'(fe_data), 0);
        q_ld = 0; q_fe = 0; q_valid = 0; q_busy = 0; m_streak = 0;
        m_ram_addr = 0; m_ram_din = 0; m_fe_data = 0;
      end else begin
        if (q_valid[0]) m_fe_data = q_data[0];
        check("m_ld_ack", 32'(ld_ack), 32'(q_ld[0]));
        check("m_ram_we", 32'(ram_we), 32'(q_ld[0]));
        check("m_fe_ack", 32'(fe_ack), 32'(q_fe[0]));
        check("m_fe_valid", 32'(fe_valid), 32'(q_valid[0]));
        check("m_busy", 32'(busy), 32'(q_busy[0]));
        check("m_ram_addr", 32'(ram_addr), 32'(m_ram_addr));
        check("m_ram_din", 32'(ram_din), 32'(m_ram_din));
        check("m_fe_data", 32'(fe_data), 32'(m_fe_data));
        if (!q_busy[0]) begin
          ld_wins = ld_req && (!fe_req || m_streak < MAX_BURST);
          if (ld_wins) begin
            q_ld[1] = 1'b1; q_busy[1] = 1'b1;
            m_ram_addr = ld_addr; m_ram_din = ld_data; m_mem[ld_addr] = ld_data;
            m_streak = fe_req ? ((m_streak + 1 > MAX_BURST) ? MAX_BURST : m_streak + 1) : 0;
          end else if (fe_req) begin
            q_fe[1] = 1'b1; q_busy[1] = 1'b1; q_busy[2] = 1'b1;
            q_valid[3] = 1'b1; q_data[3] = m_mem[fe_addr];
            m_ram_addr = fe_addr; m_streak = 0;
          end
        end
        q_ld = q_ld >> 1; q_fe = q_fe >> 1; q_valid = q_valid >> 1; q_busy = q_busy >> 1;
        for (int i = 0; i < 3; i++) q_data[i] = q_data[i+1];
        q_data[3] = 8'h00;
      end
    end
  end

  // which: 0 = ld_ack, 1 = fe_ack, 2 = fe_valid; n = cycles waited.
  task automatic wait_sig(input int which, input int max_cyc, output int n);
    logic s;
    n = 0;
    s = 1'b0;
    while (!s && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
      s = (which == 0) ? ld_ack : (which == 1) ? fe_ack : fe_valid;
    end
    check("wait_hit", 32'(s), 1);
  endtask

  int n, n_acks, pattern, n_valid, hits, ack_n;
  int v_cyc [0:1];
  logic [7:0] v_dat [0:1];

  initial begin
    rst = 1'b1; ld_req = 0; ld_addr = 0; ld_data = 0; fe_req = 0; fe_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of a write.
    ld_req = 1; ld_addr = 6'd5; ld_data = 8'hAA;
    @(posedge clk); #2;
    check("pre_rst_we", 32'(ram_we), 1);
    rst = 1'b1; #1;
    check("abort_we", 32'(ram_we), 0);
    check("abort_ld_ack", 32'(ld_ack), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ram_addr", 32'(ram_addr), 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_sig(0, 4, n);
    check("post_rst_lat", n, 1);
    check("post_rst_addr", 32'(ram_addr), 5);
    check("post_rst_din", 32'(ram_din), 32'hAA);
    ld_req = 0;
    @(posedge clk); #1;

    // Single write then read of the same address.
    ld_req = 1; ld_addr = 6'h3F; ld_data = 8'h5C;
    wait_sig(0, 4, n);
    check("wr_lat", n, 1);
    check("wr_addr", 32'(ram_addr), 32'h3F);
    ld_req = 0;
    @(posedge clk); #1;
    check("wr_idle", 32'(busy), 0);
    fe_req = 1; fe_addr = 6'h3F;
    wait_sig(1, 4, n);
    check("rd_ack_lat", n, 1);
    fe_req = 0;
    wait_sig(2, 4, n);
    check("rd_valid_lat", n, 2);
    check("rd_data", 32'(fe_data), 32'h5C);

    // Simultaneous requests with an empty streak.
    ld_req = 1; ld_addr = 6'h20; ld_data = 8'h99; fe_req = 1; fe_addr = 6'h20;
    wait_sig(0, 4, n);
    check("prio_ld_first", n, 1);
    check("prio_no_fe_ack", 32'(fe_ack), 0);
    ld_req = 0;
    wait_sig(1, 4, n);
    check("prio_fe_next", n, 2);
    fe_req = 0;
    wait_sig(2, 4, n);
    check("prio_data", 32'(fe_data), 32'h99);

    // Both held: four writes, one read, repeating.
    ld_req = 1; ld_addr = 6'h10; ld_data = 8'h77; fe_req = 1; fe_addr = 6'h10;
    n_acks = 0; pattern = 0; n_valid = 0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      if (ld_ack || fe_ack) begin
        n_acks++;
        pattern = (pattern << 1) | 32'(fe_ack);
      end
      if (fe_valid) n_valid++;
    end
    ld_req = 0; fe_req = 0;
    check("starve_acks", n_acks, 10);
    check("starve_pattern", pattern, 32'h21);
    check("starve_valids", n_valid, 2);
    check("starve_data", 32'(fe_data), 32'h77);
    @(posedge clk); #1;

    // Fetch request raised and dropped entirely within a write.
    ld_req = 1; ld_addr = 6'h02; ld_data = 8'h33;
    wait_sig(0, 4, n);
    ld_req = 0; fe_req = 1; fe_addr = 6'h02;
    @(posedge clk); #1;
    fe_req = 0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (fe_ack || fe_valid) hits++;
    end
    check("withdraw_hits", hits, 0);
    check("withdraw_busy", 32'(busy), 0);

    // Back-to-back fetches from the preloaded words.
    fe_req = 1; fe_addr = 6'h00; ack_n = 0; n_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (fe_ack) begin
        ack_n++;
        if (ack_n == 1) fe_addr = 6'h01;
        else fe_req = 0;
      end
      if (fe_valid && n_valid < 2) begin
        v_cyc[n_valid] = i;
        v_dat[n_valid] = fe_data;
        n_valid++;
      end
    end
    check("b2b_valids", n_valid, 2);
    check("b2b_cyc0", v_cyc[0], 3);
    check("b2b_cyc1", v_cyc[1], 6);
    check("b2b_dat0", 32'(v_dat[0]), 32'h11);
    check("b2b_dat1", 32'(v_dat[1]), 32'h22);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
